// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one 32-bit ALU.
// A transfer latches the result; it is held until the consumer accepts it.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [2:0]  req_op0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [2:0]  req_op1,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        lg_q;
  logic [31:0] data_q;
  logic        id_q;
  logic        err_q;

  logic        grant;
  logic        xfer;
  logic [31:0] op_a, op_b;
  logic [2:0]  op_code;
  logic [31:0] alu_res;
  logic        alu_err;
  logic        big_shift;

  // Tie goes to whoever did not win last; otherwise the lone requester wins.
  always_comb begin
    if (req_valid == 2'b11) grant = ~lg_q;
    else                    grant = req_valid[1];
  end

  always_comb begin
    req_ready = 2'b00;
    if (!reset && state_q == IDLE && req_valid[grant])
      req_ready[grant] = 1'b1;
  end

  assign xfer    = |(req_valid & req_ready);
  assign op_a    = grant ? req_a1  : req_a0;
  assign op_b    = grant ? req_b1  : req_b0;
  assign op_code = grant ? req_op1 : req_op0;

  // Shift amount is the whole of B, so anything >= 32 saturates.
  assign big_shift = |op_b[31:5];

  always_comb begin
    alu_res = 32'd0;
    alu_err = 1'b0;
    case (op_code)
      3'd0: alu_res = op_a + op_b;
      3'd1: alu_res = op_a - op_b;
      3'd2: alu_res = op_a & op_b;
      3'd3: alu_res = op_a | op_b;
      3'd4: alu_res = big_shift ? 32'd0 : (op_a >> op_b[4:0]);
      3'd5: alu_res = big_shift ? {32{op_a[31]}} : 32'($signed(op_a) >>> op_b[4:0]);
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lg_q    <= 1'b1;
      data_q  <= 32'd0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        lg_q   <= grant;
        data_q <= alu_res;
        id_q   <= grant;
        err_q  <= alu_err;
      end
    end
  end

  assign rsp_valid = (state_q == HOLD);
  assign busy      = (state_q == HOLD);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle plus
// directed vectors with literal expected values.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [31:0] req_a0 = 32'd0, req_b0 = 32'd0, req_a1 = 32'd0, req_b1 = 32'd0;
  logic [2:0]  req_op0 = 3'd0, req_op1 = 3'd0;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int passed = 0;

  alu_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference ALU written from the opcode table, shifting one bit at a time.
  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] r;
    r = a;
    case (op)
      3'd0: return {1'b0, a + b};
      3'd1: return {1'b0, a - b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: begin
        for (int i = 0; i < 32; i++) if (i < b) r = {1'b0, r[31:1]};
        return {1'b0, r};
      end
      3'd5: begin
        for (int i = 0; i < 32; i++) if (i < b) r = {r[31], r[31:1]};
        return {1'b0, r};
      end
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Transaction model: one outstanding result, last-winner pointer.
  logic        m_hold = 1'b0;
  logic        m_lg = 1'b1;
  logic [31:0] m_data = 32'd0;
  logic        m_id = 1'b0;
  logic        m_err = 1'b0;

  function automatic logic [1:0] model_ready();
    if (reset || m_hold || req_valid == 2'b00) return 2'b00;
    if (req_valid == 2'b11) return m_lg ? 2'b01 : 2'b10;
    return req_valid;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hold <= 1'b0; m_lg <= 1'b1; m_data <= 32'd0; m_id <= 1'b0; m_err <= 1'b0;
    end else if (m_hold) begin
      if (rsp_ready) m_hold <= 1'b0;
    end else if (req_valid != 2'b00) begin
      logic w;
      logic [32:0] r;
      w = (req_valid == 2'b11) ? ~m_lg : req_valid[1];
      r = w ? ref_alu(req_a1, req_b1, req_op1) : ref_alu(req_a0, req_b0, req_op0);
      m_hold <= 1'b1; m_lg <= w; m_id <= w; m_data <= r[31:0]; m_err <= r[32];
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_data", rsp_data, 32'd0);
    end else begin
      chk("m_ready", {30'd0, req_ready}, {30'd0, model_ready()});
      chk("m_valid", {31'd0, rsp_valid}, {31'd0, m_hold});
      chk("m_busy", {31'd0, busy}, {31'd0, m_hold});
      if (m_hold) begin
        chk("m_data", rsp_data, m_data);
        chk("m_id", {31'd0, rsp_id}, {31'd0, m_id});
        chk("m_err", {31'd0, rsp_err}, {31'd0, m_err});
      end
    end
  end

  // Starts #1 after a rising edge; returns #1 after the transfer edge.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    int n;
    n = 0;
    if (id == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; req_valid = 2'b01; end
    else         begin req_a1 = a; req_b1 = b; req_op1 = op; req_valid = 2'b10; end
    #1;
    while (!req_ready[id] && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready[id]) begin
      checks++;
      $display("FAIL op_timeout: got req_ready=%b expected grant to %0d", req_ready, id);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic pulse_reset();
    req_valid = 2'b00;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [1:0] tie_exp [8];

  initial begin
    tie_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    req_valid = 2'b11;
    @(posedge clk); #1;
    chk("reset_ready", {30'd0, req_ready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    req_valid = 2'b00;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single subtract, latency 1, back to IDLE after accept.
    rsp_ready = 1'b1;
    do_op(0, 32'd5, 32'd3, 3'd1);
    chk("sub_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sub_data", rsp_data, 32'd2);
    chk("sub_id", {31'd0, rsp_id}, 32'd0);
    chk("sub_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1;
    chk("sub_idle", {31'd0, busy}, 32'd0);

    // Tie after reset alternates 0,1,0,1 every other cycle.
    pulse_reset();
    req_a0 = 32'd10; req_b0 = 32'd1; req_op0 = 3'd0;
    req_a1 = 32'd20; req_b1 = 32'd2; req_op1 = 3'd0;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 8; k++) begin
      $display("tie cycle %0d req_ready=%b", k, req_ready);
      chk("tie_ready", {30'd0, req_ready}, {30'd0, tie_exp[k]});
      @(posedge clk); #2;
    end
    req_valid = 2'b00;
    @(posedge clk); #1;

    do_op(0, 32'h8000_0000, 32'd31, 3'd4);
    chk("srl31", rsp_data, 32'h0000_0001);
    @(posedge clk); #1;
    do_op(0, 32'h8000_0000, 32'd4, 3'd5);
    chk("sra4", rsp_data, 32'hF800_0000);
    @(posedge clk); #1;
    do_op(0, 32'h8000_0000, 32'd40, 3'd5);
    chk("sra40", rsp_data, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    do_op(0, 32'h8000_0000, 32'd40, 3'd4);
    chk("srl40", rsp_data, 32'h0000_0000);
    @(posedge clk); #1;
    do_op(1, 32'h0000_00F0, 32'h0000_0F0F, 3'd3);
    chk("or", rsp_data, 32'h0000_0FFF);
    @(posedge clk); #1;

    // Backpressure: result held, both requesters blocked.
    rsp_ready = 1'b0;
    do_op(0, 32'hFFFF_FFFF, 32'd1, 3'd0);
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      $display("hold cycle %0d rsp_data=%h req_ready=%b", k, rsp_data, req_ready);
      chk("bp_data", rsp_data, 32'd0);
      chk("bp_ready", {30'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done", {31'd0, busy}, 32'd0);
    req_valid = 2'b00;
    @(posedge clk); #1;

    // Illegal opcode from requester 1, then a tie must go to requester 0.
    do_op(1, 32'h1234, 32'h1234, 3'd7);
    chk("ill_data", rsp_data, 32'd0);
    chk("ill_err", {31'd0, rsp_err}, 32'd1);
    chk("ill_id", {31'd0, rsp_id}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b11;
    #1;
    chk("ill_tie", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;

    // Asynchronous reset while a result is held.
    rsp_ready = 1'b0;
    do_op(1, 32'd7, 32'd8, 3'd0);
    chk("pre_rst_data", rsp_data, 32'd15);
    #1 reset = 1'b1;
    #1;
    chk("ar_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ar_data", rsp_data, 32'd0);
    chk("ar_id", {31'd0, rsp_id}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    end
    rsp_ready = 1'b1;
    do_op(0, 32'h0F0F_0F0F, 32'hFF00_FF00, 3'd2);
    chk("and", rsp_data, 32'h0F00_0F00);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
